// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples SCLK/CS_n/MOSI in the clk domain and exchanges
// MSB-first bytes in all four CPOL/CPHA modes, with a one-byte TX buffer.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_d, lead, trail;
  logic [7:0] tx_buf, tx_shift, rx_shift;
  logic [2:0] bit_cnt;
  logic       reload_pend, miso_q;
  logic       load_evt, sample_evt, shift_evt, cs_rise;
  logic [7:0] load_byte;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // CS synchronizer resets high so reset release never looks like a select.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update from pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      lead      <= 1'b0;
      trail     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      lead      <= (sclk_s != sclk_d) && (sclk_s != cpol);
      trail     <= (sclk_s != sclk_d) && (sclk_s == cpol);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    load_evt   = 1'b0;
    sample_evt = 1'b0;
    shift_evt  = 1'b0;
    cs_rise    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d  = ACTIVE;
          load_evt = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d = IDLE;
          cs_rise = 1'b1;
        end else begin
          // cpha=0 reloads on the trail edge that would otherwise shift.
          load_evt   = reload_pend && (cpha || trail);
          sample_evt = cpha ? trail : lead;
          shift_evt  = !load_evt && (cpha ? lead : trail);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_byte = tx_load ? tx_data : tx_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf      <= 8'h00;
      tx_empty    <= 1'b1;
      tx_shift    <= 8'h00;
      rx_shift    <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      bit_cnt     <= 3'd0;
      reload_pend <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // A load coinciding with a byte load event bypasses the buffer.
      if (tx_load && !load_evt) begin
        tx_buf   <= tx_data;
        tx_empty <= 1'b0;
      end
      if (cs_rise) begin
        bit_cnt     <= 3'd0;
        rx_shift    <= 8'h00;
        miso_q      <= 1'b0;
        reload_pend <= 1'b0;
      end else begin
        if (load_evt) begin
          tx_shift    <= load_byte;
          tx_empty    <= 1'b1;
          reload_pend <= 1'b0;
          if (!cpha) miso_q <= load_byte[7];
        end else if (shift_evt) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          miso_q   <= cpha ? tx_shift[7] : tx_shift[6];
        end
        if (sample_evt) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data     <= {rx_shift[6:0], mosi_s};
            rx_valid    <= 1'b1;
            reload_pend <= 1'b1;
          end
        end
      end
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign spi_miso_oe = busy;
  assign spi_miso    = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives directed and
// random transfers; expected bytes come from a simple last-loaded-byte model.
module tb_spi_slave;
  localparam int SYNC_STAGES = 2;
  localparam int H = 8;  // SCLK half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n, cpol, cpha, tx_load, tx_empty, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] m_buf;  // model of the TX buffer: last byte handed to the slave

  spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_valid) rx_q.push_back(rx_data);

  initial begin
    #900_000;
    $display("FAIL timeout: simulation did not finish (got running, want done)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    m_buf   = d;
    cyc(1);
    tx_load = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    cpol     = m[1];
    cpha     = m[0];
    spi_sclk = m[1];
    cyc(2 * H);
  endtask

  task automatic cs_low();
    rx_q.delete();
    spi_cs_n = 1'b0;
    cyc(H);
  endtask

  task automatic cs_high();
    cyc(H);
    spi_cs_n = 1'b1;
    cyc(2 * H);
  endtask

  // Master side of one byte; optionally loads the slave's next byte after bit 4.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit do_ld,
                          input logic [7:0] ld_d, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        spi_mosi = mo[i];
        cyc(H);
        mi[i]    = spi_miso;
        spi_sclk = ~cpol;
        cyc(H);
        spi_sclk = cpol;
      end else begin
        spi_sclk = ~cpol;
        spi_mosi = mo[i];
        cyc(H);
        mi[i]    = spi_miso;
        spi_sclk = cpol;
        cyc(H);
      end
      if (do_ld && i == 4) load(ld_d);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_miso"}, spi_miso, 1'b0);
    check({tag, "_miso_oe"}, spi_miso_oe, 1'b0);
  endtask

  initial begin
    logic [7:0] mi, mi2, prev_rx;
    logic [7:0] mo_arr[3];
    logic [7:0] ld_arr[3];
    bit         ld_en[3];
    logic [7:0] exp_out;
    int         n;

    rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h00; tx_load = 1'b0;
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; m_buf = 8'h00;
    cyc(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_empty", tx_empty, 1'b1);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    cyc(4);

    // Mode 0 single byte
    set_mode(2'd0);
    load(8'hA5);
    check("m0_tx_empty_loaded", tx_empty, 1'b0);
    cs_low();
    check("m0_busy", busy, 1'b1);
    check("m0_miso_oe", spi_miso_oe, 1'b1);
    spi_byte(8'h3C, 8, 1'b0, 8'h00, mi);
    cs_high();
    check("m0_master_rx", mi, 8'hA5);
    check("m0_rx_pulses", rx_q.size(), 1);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_tx_empty", tx_empty, 1'b1);
    check_idle_outputs("m0_end");

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1:0]);
      load(8'h69);
      cs_low();
      spi_byte(8'h96, 8, 1'b0, 8'h00, mi);
      cs_high();
      check($sformatf("mode%0d_master_rx", m), mi, 8'h69);
      check($sformatf("mode%0d_rx_pulses", m), rx_q.size(), 1);
      check($sformatf("mode%0d_rx_data", m), rx_data, 8'h96);
    end

    // Two bytes in one CS, next byte loaded during byte 1
    set_mode(2'd0);
    load(8'h11);
    cs_low();
    spi_byte(8'hF0, 8, 1'b1, 8'h22, mi);
    spi_byte(8'h0F, 8, 1'b0, 8'h00, mi2);
    cs_high();
    check("two_miso0", mi, 8'h11);
    check("two_miso1", mi2, 8'h22);
    check("two_rx_pulses", rx_q.size(), 2);
    check("two_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hF0);
    check("two_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h0F);

    // Underrun: one load, two bytes
    set_mode(2'd3);
    load(8'h5A);
    check("ur_tx_empty_pre", tx_empty, 1'b0);
    cs_low();
    check("ur_tx_empty_first", tx_empty, 1'b1);
    spi_byte(8'h12, 8, 1'b0, 8'h00, mi);
    spi_byte(8'h34, 8, 1'b0, 8'h00, mi2);
    cs_high();
    check("ur_miso0", mi, 8'h5A);
    check("ur_miso1", mi2, 8'h5A);
    check("ur_tx_empty_end", tx_empty, 1'b1);

    // Abort after 5 bits, then a clean byte
    set_mode(2'd0);
    prev_rx = rx_data;
    cs_low();
    spi_byte(8'hFF, 5, 1'b0, 8'h00, mi);
    cs_high();
    check("abort_rx_pulses", rx_q.size(), 0);
    check("abort_rx_data", rx_data, prev_rx);
    check_idle_outputs("abort");
    cs_low();
    spi_byte(8'hC3, 8, 1'b0, 8'h00, mi);
    cs_high();
    check("abort_next_rx_pulses", rx_q.size(), 1);
    check("abort_next_rx_data", rx_data, 8'hC3);

    // Asynchronous reset mid-transfer
    set_mode(2'd1);
    cs_low();
    spi_byte(8'hE7, 3, 1'b0, 8'h00, mi);
    load(8'h77);
    check("mid_tx_empty", tx_empty, 1'b0);
    cyc(1);
    #2;
    rst_n = 1'b0;
    m_buf = 8'h00;
    #1;
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_tx_empty", tx_empty, 1'b1);
    check_idle_outputs("arst");
    spi_cs_n = 1'b1;
    spi_sclk = cpol;
    cyc(4);
    rst_n = 1'b1;
    cyc(2 * H);
    check("post_rst_miso", spi_miso, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // Randomized bursts against the last-loaded-byte model
    for (int it = 0; it < 24; it++) begin
      set_mode(2'($urandom_range(3)));
      n = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) begin
        mo_arr[k] = 8'($urandom);
        ld_arr[k] = 8'($urandom);
        ld_en[k]  = ($urandom_range(3) != 0);
      end
      if (ld_en[0]) load(ld_arr[0]);
      cs_low();
      for (int k = 0; k < n; k++) begin
        exp_out = m_buf;
        spi_byte(mo_arr[k], 8, (k + 1 < n) && ld_en[k + 1],
                 (k + 1 < 3) ? ld_arr[(k + 1) % 3] : 8'h00, mi);
        check($sformatf("rnd%0d_miso%0d", it, k), mi, exp_out);
      end
      cs_high();
      check($sformatf("rnd%0d_rx_pulses", it), rx_q.size(), n);
      for (int k = 0; k < n; k++)
        check($sformatf("rnd%0d_rx%0d", it, k), (k < rx_q.size()) ? rx_q[k] : 8'hxx, mo_arr[k]);
      check($sformatf("rnd%0d_tx_empty", it), tx_empty, 1'b1);
      check($sformatf("rnd%0d_busy", it), busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
